// File: rtl/calc2_pkg.sv
// calc2_pkg: command/response encodings, default sizes and unit-decode helpers
package calc2_pkg;
  localparam int NCH_D = 4;
  localparam int DW_D = 32;
  localparam int DEPTH_D = 2;
  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;
  typedef enum logic [1:0] {RSP_NONE, RSP_OK, RSP_INV, RSP_PROT} rsp_e;
  function automatic logic is_as(input logic [3:0] c);
    return c == CMD_ADD || c == CMD_SUB;
  endfunction
  function automatic logic is_sh(input logic [3:0] c);
    return c == CMD_SHL || c == CMD_SHR;
  endfunction
endpackage

// File: rtl/calc2_rr_arb.sv
// calc2_rr_arb: round-robin arbiter, pointer moves to granted+1 after each grant
module calc2_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt, k;
  always_comb begin
    gnt = '0;
    nxt = ptr;
    k = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (gnt == '0 && req[k]) begin
        gnt[k] = 1'b1;
        nxt = PW'((int'(k) + 1) % N);
      end
    end
  end
  always_ff @(posedge clk) ptr <= rst ? '0 : nxt;
endmodule

// File: rtl/calc2_core.sv
// calc2_core: multi-channel two-beat add/sub/shift engine with shared, round-robin arbitrated units
module calc2_core
  import calc2_pkg::*;
#(
  parameter int NCH = NCH_D,
  parameter int DW = DW_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [NCH*4-1:0]  req_cmd_in,
  input  logic [NCH*DW-1:0] req_data_in,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH*2-1:0]  out_resp,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    req_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int SW = $clog2(DW);
  logic [3:0] f_cmd [NCH][DEPTH];
  logic [DW-1:0] f_a [NCH][DEPTH];
  logic [DW-1:0] f_b [NCH][DEPTH];
  logic [AW-1:0] rp [NCH];
  logic [AW-1:0] wp [NCH];
  logic [CW-1:0] cnt [NCH];
  logic [3:0] cap_cmd [NCH];
  logic [DW-1:0] cap_a [NCH];
  logic [3:0] hc [NCH];
  logic [1:0] rsp_r [NCH];
  logic [DW-1:0] dat_r [NCH];
  logic [NCH-1:0] cap, inv_s, err_pend, rdy, start, drop;
  logic [NCH-1:0] as_req, sh_req, as_gnt, sh_gnt, inv_pop, pop, as_hit, sh_hit;
  logic as_v, sh_v;
  logic [HW-1:0] as_ch, sh_ch;
  logic [3:0] as_cmd, sh_cmd;
  logic [DW-1:0] as_a, as_b, sh_a, sh_b, as_dat, sh_dat;
  logic [DW:0] sum;
  logic [1:0] as_rsp;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  calc2_rr_arb #(.N(NCH)) u_as_arb (.clk(c_clk), .rst(reset), .req(as_req), .gnt(as_gnt));
  calc2_rr_arb #(.N(NCH)) u_sh_arb (.clk(c_clk), .rst(reset), .req(sh_req), .gnt(sh_gnt));
  assign pop = inv_pop | as_gnt | sh_gnt;
  always_comb begin
    as_req = '0;
    sh_req = '0;
    inv_pop = '0;
    rdy = '0;
    start = '0;
    drop = '0;
    as_hit = '0;
    sh_hit = '0;
    req_ready = '0;
    out_resp = '0;
    out_data = '0;
    for (int c = 0; c < NCH; c++) begin
      hc[c] = f_cmd[c][rp[c]];
      as_req[c] = cnt[c] != '0 && is_as(hc[c]);
      sh_req[c] = cnt[c] != '0 && is_sh(hc[c]);
      inv_pop[c] = cnt[c] != '0 && !is_as(hc[c]) && !is_sh(hc[c]);
      rdy[c] = int'(cnt[c]) + int'(cap[c]) < DEPTH;
      start[c] = !cap[c] && req_cmd_in[c*4 +: 4] != CMD_NOP;
      drop[c] = start[c] && !rdy[c];
      as_hit[c] = as_v && as_ch == HW'(c);
      sh_hit[c] = sh_v && sh_ch == HW'(c);
      req_ready[c] = reset || rdy[c];
      out_resp[c*2 +: 2] = reset ? '0 : rsp_r[c];
      out_data[c*DW +: DW] = reset ? '0 : dat_r[c];
    end
  end
  // Overflow/underflow results are forced to zero data alongside the invalid response
  always_comb begin
    sum = {1'b0, as_a} + {1'b0, as_b};
    as_rsp = (as_cmd == CMD_ADD ? sum[DW] : as_b > as_a) ? RSP_INV : RSP_OK;
    as_dat = as_rsp == RSP_INV ? '0 : as_cmd == CMD_ADD ? sum[DW-1:0] : as_a - as_b;
    sh_dat = sh_cmd == CMD_SHL ? sh_a << sh_b[SW-1:0] : sh_a >> sh_b[SW-1:0];
  end
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap <= '0;
      inv_s <= '0;
      err_pend <= '0;
      req_err <= '0;
      as_v <= 1'b0;
      sh_v <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        rp[c] <= '0;
        wp[c] <= '0;
        cnt[c] <= '0;
        rsp_r[c] <= '0;
        dat_r[c] <= '0;
      end
    end else begin
      as_v <= |as_gnt;
      sh_v <= |sh_gnt;
      inv_s <= inv_pop;
      req_err <= req_err | drop;
      cap <= start & rdy;
      for (int c = 0; c < NCH; c++) begin
        if (start[c] && rdy[c]) begin
          cap_cmd[c] <= req_cmd_in[c*4 +: 4];
          cap_a[c] <= req_data_in[c*DW +: DW];
        end
        if (cap[c]) begin
          f_cmd[c][wp[c]] <= cap_cmd[c];
          f_a[c][wp[c]] <= cap_a[c];
          f_b[c][wp[c]] <= req_data_in[c*DW +: DW];
          wp[c] <= inc(wp[c]);
        end
        if (pop[c]) rp[c] <= inc(rp[c]);
        cnt[c] <= cnt[c] + CW'(cap[c]) - CW'(pop[c]);
        if (as_gnt[c]) begin
          as_ch <= HW'(c);
          as_cmd <= hc[c];
          as_a <= f_a[c][rp[c]];
          as_b <= f_b[c][rp[c]];
        end
        if (sh_gnt[c]) begin
          sh_ch <= HW'(c);
          sh_cmd <= hc[c];
          sh_a <= f_a[c][rp[c]];
          sh_b <= f_b[c][rp[c]];
        end
        rsp_r[c] <= as_hit[c] ? as_rsp : sh_hit[c] ? RSP_OK : inv_s[c] ? RSP_INV : err_pend[c] ? RSP_PROT : RSP_NONE;
        dat_r[c] <= as_hit[c] ? as_dat : sh_hit[c] ? sh_dat : '0;
        // A protocol error waits for an edge with no result of its own on this channel
        err_pend[c] <= drop[c] || (err_pend[c] && (as_hit[c] || sh_hit[c] || inv_s[c]));
      end
    end
  end
endmodule

// File: tb/tb_calc2_core.sv
// tb_calc2_core: table-driven vectors and corner sequences, scored against a timed expectation queue
module tb_calc2_core;
  import calc2_pkg::*;
  localparam int NCH = 4;
  localparam int DW = 32;
  localparam int DEPTH = 2;
  logic c_clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH*4-1:0] req_cmd_in = '0;
  logic [NCH*DW-1:0] req_data_in = '0;
  logic [NCH-1:0] req_ready, req_err;
  logic [NCH*2-1:0] out_resp;
  logic [NCH*DW-1:0] out_data;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t0, t1;
  typedef struct {int ch; int cyc; logic [1:0] rsp; logic [DW-1:0] dat;} exp_t;
  typedef struct {int ch; logic [3:0] cmd; logic [DW-1:0] a; logic [DW-1:0] b; logic [1:0] rsp; logic [DW-1:0] dat;} vec_t;
  exp_t q[$];
  vec_t vecs[13];
  calc2_core #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .req_err(req_err)
  );
  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask
  task automatic expect_at(input int ch, input int at, input logic [1:0] rsp, input logic [DW-1:0] dat);
    exp_t e;
    e.ch = ch;
    e.cyc = at;
    e.rsp = rsp;
    e.dat = dat;
    q.push_back(e);
  endtask
  function automatic logic [NCH*4-1:0] cv(input int ch, input logic [3:0] cmd);
    logic [NCH*4-1:0] v;
    v = '0;
    v[ch*4 +: 4] = cmd;
    return v;
  endfunction
  function automatic logic [NCH*DW-1:0] dv(input int ch, input logic [DW-1:0] x);
    logic [NCH*DW-1:0] v;
    v = '0;
    v[ch*DW +: DW] = x;
    return v;
  endfunction
  task automatic pair(input logic [NCH*4-1:0] cmds, input logic [NCH*DW-1:0] op1, input logic [NCH*DW-1:0] op2);
    req_cmd_in = cmds;
    req_data_in = op1;
    step();
    req_cmd_in = '0;
    req_data_in = op2;
    step();
    req_data_in = '0;
  endtask
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    chk("ready in reset", 64'(req_ready), 64'hF);
    reset = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) step();
    chk("drain leftover", 64'(q.size()), 0);
    q.delete();
  endtask
  // Every channel every cycle: either the scheduled response or all-zero idle
  always @(negedge c_clk) begin
    int k;
    logic [1:0] r;
    logic [DW-1:0] d;
    for (int c = 0; c < NCH; c++) begin
      k = -1;
      foreach (q[i]) if (q[i].ch == c && q[i].cyc == cyc) k = i;
      r = out_resp[c*2 +: 2];
      d = out_data[c*DW +: DW];
      if (k >= 0) begin
        chk($sformatf("resp ch%0d", c), 64'(r), 64'(q[k].rsp));
        chk($sformatf("data ch%0d", c), 64'(d), 64'(q[k].dat));
        q.delete(k);
      end else chk($sformatf("idle ch%0d", c), {30'd0, r, d}, 0);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vecs[0]  = '{0, CMD_ADD, 32'h5, 32'h7, RSP_OK, 32'hC};
    vecs[1]  = '{1, CMD_ADD, 32'hFFFFFFFF, 32'h1, RSP_INV, 32'h0};
    vecs[2]  = '{1, CMD_SUB, 32'h3, 32'h5, RSP_INV, 32'h0};
    vecs[3]  = '{1, CMD_SHL, 32'h1, 32'h21, RSP_OK, 32'h2};
    vecs[4]  = '{2, CMD_SUB, 32'd10, 32'd3, RSP_OK, 32'h7};
    vecs[5]  = '{3, CMD_SHR, 32'h80000000, 32'h4, RSP_OK, 32'h08000000};
    vecs[6]  = '{0, CMD_SHL, 32'h1, 32'd31, RSP_OK, 32'h80000000};
    vecs[7]  = '{2, CMD_ADD, 32'h80000000, 32'h7FFFFFFF, RSP_OK, 32'hFFFFFFFF};
    vecs[8]  = '{3, CMD_SUB, 32'h5, 32'h5, RSP_OK, 32'h0};
    vecs[9]  = '{0, 4'd3, 32'h12, 32'h34, RSP_INV, 32'h0};
    vecs[10] = '{1, 4'd15, 32'h1, 32'h1, RSP_INV, 32'h0};
    vecs[11] = '{2, CMD_SHR, 32'hF0, 32'hFFFFFFE4, RSP_OK, 32'hF};
    vecs[12] = '{3, CMD_SUB, 32'h0, 32'h1, RSP_INV, 32'h0};
    // Reset with commands presented: ignored, no error flag
    req_cmd_in = {NCH{4'd1}};
    req_data_in = '1;
    repeat (3) step();
    chk("ready in reset", 64'(req_ready), 64'hF);
    chk("resp in reset", 64'(out_resp), 0);
    chk("err in reset", 64'(req_err), 0);
    req_cmd_in = '0;
    req_data_in = '0;
    reset = 1'b0;
    step();
    chk("ready after reset", 64'(req_ready), 64'hF);
    chk("err after reset", 64'(req_err), 0);
    chk("resp after reset", 64'(out_resp), 0);
    chk("data after reset", 64'(out_data), 0);
    // Uncontended table, issued back to back
    foreach (vecs[i]) begin
      t0 = cyc;
      expect_at(vecs[i].ch, t0 + 4, vecs[i].rsp, vecs[i].dat);
      pair(cv(vecs[i].ch, vecs[i].cmd), dv(vecs[i].ch, vecs[i].a), dv(vecs[i].ch, vecs[i].b));
    end
    drain();
    // Different units issue in the same cycle
    t0 = cyc;
    expect_at(0, t0 + 4, RSP_OK, 32'h08000000);
    expect_at(1, t0 + 4, RSP_OK, 32'h7);
    pair(cv(0, CMD_SHR) | cv(1, CMD_SUB), dv(0, 32'h80000000) | dv(1, 32'd10), dv(0, 32'h4) | dv(1, 32'd3));
    t0 = cyc;
    expect_at(2, t0 + 4, RSP_OK, 32'h5);
    expect_at(3, t0 + 4, RSP_OK, 32'hC);
    pair(cv(2, CMD_ADD) | cv(3, CMD_SHL), dv(2, 32'h2) | dv(3, 32'h3), dv(2, 32'h3) | dv(3, 32'h2));
    drain();
    // Round-robin burst twice back to back: second burst follows ch3 and restarts at ch0
    do_reset(2);
    t0 = cyc;
    for (int c = 0; c < NCH; c++) expect_at(c, t0 + 4 + c, RSP_OK, 32'h2);
    pair({NCH{CMD_ADD}}, {NCH{32'h1}}, {NCH{32'h1}});
    t1 = cyc;
    for (int c = 0; c < NCH; c++) expect_at(c, t1 + 6 + c, RSP_OK, 32'h2);
    pair({NCH{CMD_ADD}}, {NCH{32'h1}}, {NCH{32'h1}});
    drain();
    // ch2 fills its buffer behind ch0/ch1 on the shift unit; third request dropped
    do_reset(2);
    t0 = cyc;
    expect_at(0, t0 + 4, RSP_OK, 32'h2);
    expect_at(1, t0 + 5, RSP_OK, 32'h4);
    expect_at(2, t0 + 6, RSP_OK, 32'h8);
    expect_at(2, t0 + 7, RSP_OK, 32'h10);
    expect_at(2, t0 + 8, RSP_PROT, 32'h0);
    pair(cv(0, CMD_SHL) | cv(1, CMD_SHL) | cv(2, CMD_SHL), {NCH{32'h1}}, dv(0, 32'h1) | dv(1, 32'h2) | dv(2, 32'h3));
    pair(cv(2, CMD_SHL), dv(2, 32'h1), dv(2, 32'h4));
    chk("ready ch2 full", 64'(req_ready[2]), 0);
    chk("err before drop", 64'(req_err), 0);
    pair(cv(2, CMD_SHL), dv(2, 32'h1), dv(2, 32'h5));
    chk("err set on drop", 64'(req_err), 64'h4);
    drain();
    repeat (5) step();
    chk("err sticky", 64'(req_err), 64'h4);
    // Reset during ch3 operand2 abandons the request
    req_cmd_in = cv(3, CMD_SUB);
    req_data_in = dv(3, 32'd9);
    step();
    req_cmd_in = '0;
    req_data_in = dv(3, 32'd4);
    reset = 1'b1;
    step();
    req_data_in = '0;
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("err cleared by reset", 64'(req_err), 0);
    t0 = cyc;
    expect_at(3, t0 + 4, RSP_OK, 32'h5);
    pair(cv(3, CMD_SUB), dv(3, 32'd9), dv(3, 32'd4));
    drain();
    chk("queue empty", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/calc2_core.md
CALC2_CORE -- requirements
Module: calc2_core

Interface
REQ-001 Parameter NCH, default 4: number of independent request/response channels (1..8).
REQ-002 Parameter DW, default 32: operand and result width in bits (8..64, power of two).
REQ-003 Parameter DEPTH, default 2: per-channel pending-request buffer entries (1..8).
REQ-004 c_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_cmd_in  in  NCH*4  per-channel command: 0 NOP, 1 ADD, 2 SUB, 5 SHL, 6 SHR, others invalid.
REQ-007 req_data_in  in  NCH*DW  per-channel operand: operand1 in the cmd cycle, operand2 in the next cycle.
REQ-008 req_ready  out  NCH  high when the channel's buffer can accept one more request.
REQ-009 out_resp  out  NCH*2  per-channel response: 0 none, 1 success, 2 invalid/overflow, 3 protocol error.
REQ-010 out_data  out  NCH*DW  per-channel result, qualified by out_resp==1.
REQ-011 req_err  out  NCH  sticky flag: a command was dropped on this channel.

Function
REQ-012 A channel SHALL sample a nonzero req_cmd_in with operand1 only in a cycle where it is not awaiting operand2; the following cycle is always captured as operand2, whatever req_cmd_in holds.
REQ-013 A request SHALL be written to its channel FIFO at the operand2 edge; req_ready SHALL be low when occupancy plus any in-capture request equals DEPTH.
REQ-014 A nonzero command sampled while req_ready is low SHALL be dropped, set req_err[ch], and drive out_resp=3, out_data=0 for one cycle at the next edge that carries no result for that channel.
REQ-015 One shared add/sub unit and one shared shift unit SHALL each issue at most one request per cycle.
REQ-016 Each unit SHALL arbitrate round-robin among channels whose FIFO head targets it; the pointer starts at channel 0 after reset and moves to granted+1 mod NCH after each grant.
REQ-017 A channel SHALL complete its requests strictly in acceptance order; only the FIFO head is eligible.
REQ-018 An invalid-command head SHALL retire without arbitration, giving out_resp=2, out_data=0.
REQ-019 ADD: carry out of DW bits gives resp 2, data 0; else resp 1, data = sum mod 2^DW.
REQ-020 SUB: operand2 > operand1 (unsigned) gives resp 2, data 0; else resp 1, data = difference.
REQ-021 SHL/SHR: logical shift of operand1 by operand2[clog2(DW)-1:0], upper operand2 bits ignored, always resp 1.
REQ-022 Uncontended latency: cmd sampled at edge t gives result registered at edge t+3, held exactly one cycle; then out_resp=0, out_data=0.
REQ-023 A channel SHALL accept a new command every second cycle (cmd at t+2 after cmd at t) when ready.
REQ-024 A response-2 result SHALL NOT block the channel; subsequent requests proceed normally.
REQ-025 ADD and SHL heads on different channels SHALL issue in the same cycle.

Reset
REQ-026 reset SHALL flush all FIFOs, abandon any in-capture operand2, clear req_err, zero both arbiter pointers.
REQ-027 During and on the edge after reset: out_resp=0, out_data=0, req_ready=all ones; commands presented during reset are ignored without setting req_err.

Structure
REQ-028 Package calc2_pkg SHALL hold the command and response encodings and the default DW/NCH/DEPTH values.
REQ-029 Sub-module calc2_rr_arb (NCH-wide request vector, one-hot grant, rotating pointer) SHALL be instantiated once per unit.

Verification
REQ-030 ch0 ADD 0x00000005, 0x00000007 at t -> ch0 out_resp=1, out_data=0x0000000C after edge t+3, zero next cycle.
REQ-031 ch0..ch3 ADD 1,1 simultaneously -> results in consecutive cycles in order ch0, ch1, ch2, ch3; second identical burst again starts at ch0 (pointer wrap).
REQ-032 ch1 ADD 0xFFFFFFFF,1 then SUB 3,5 then SHL 1,0x21 -> resp 2 data 0, resp 2 data 0, resp 1 data 0x00000002.
REQ-033 DEPTH=2, ch2 issues three requests with no arbitration slot free (shift unit saturated by ch0/ch1) -> third is dropped, out_resp[2]=3 once, req_err[2]=1 until reset.
REQ-034 reset asserted on ch3 operand2 cycle of SUB 9,4 -> no ch3 response ever appears; first post-reset request completes normally.
REQ-035 ch0 SHR 0x80000000,4 and ch1 SUB 10,3 same cycle -> both complete at t+3: 0x08000000 and 0x00000007.
